pg_match_unpacker: RTL and testbench
====================================

// Module: pg_match_unpacker
// PURPOSE
//  Consumer of the 512-bit packed rule-match stream that the port-group stage emits toward PCIe/host.
//  Per packet: takes one metadata_t record and 512-bit words up to and including the eop word.
//  Emits each non-zero rule ID serially with the packet metadata, then one terminator beat.
//  Sits at the host/check side, feeding per-rule full-match logic.
// PARAMETERS
//  DATA_WIDTH     512          input word width (4 lanes x 128 bits)
//  SLOT_WIDTH     16           bits per slot; slot = {pad, rule ID}
//  NUM_SLOTS      32           DATA_WIDTH/SLOT_WIDTH; slot k = in_match_data[16k+15:16k]
//  RULE_ID_WIDTH  RULE_AWIDTH  significant low bits of a slot (13 by default)
// PORTS
//  clk              in   1    clock
//  rst_n            in   1    reset: asynchronous assert, active-low
//  in_match_data    in   512  packed slots
//  in_match_valid   in   1    word valid
//  in_match_eop     in   1    last word of packet
//  in_match_sop     in   1    ignored
//  in_match_empty   in   6    ignored
//  in_match_ready   out  1    word accepted when valid&ready
//  in_meta_valid    in   1    metadata record available
//  in_meta_data     in   metadata_t  packet metadata
//  in_meta_ready    out  1    one-cycle pop pulse per packet
//  out_rule_valid   out  1    rule beat valid
//  out_rule_id      out  RULE_ID_WIDTH  rule ID; 0 on terminator beat
//  out_rule_last    out  1    terminator beat of packet
//  out_meta_data    out  metadata_t  metadata of current packet, stable for whole packet
//  out_rule_ready   in   1    downstream accept
//  rule_cnt         out  32   rule beats handed off (terminators excluded), wraps
//  pkt_cnt          out  32   terminators handed off, wraps
// BEHAVIOUR
//  Reset values: every output and counter 0, FSM in IDLE, slot mask 0.
//   Reset acts immediately, mid-packet included: partial packet dropped, no meta pop.
//  Slot occupancy: slot occupied iff its low RULE_ID_WIDTH bits != 0. Bits [15:RULE_ID_WIDTH] are ignored.
//  FSM
//   IDLE
//    - Waits for in_meta_valid.
//    - Latches in_meta_data into out_meta_data.
//    - Goes to LOAD next cycle.
//   LOAD
//    - in_match_ready=1, and only in this state.
//    - On handshake: registers occupancy mask (32b), slot data, and eop flag.
//    - Next state is SCAN if mask != 0, else TERM if eop, else stays in LOAD.
//   SCAN
//    - Presents the lowest-index set slot: out_rule_valid=1, out_rule_id=slot ID.
//    - On out_rule_ready, clears that bit.
//    - Last bit consumed: goes to TERM if eop, else LOAD.
//   TERM
//    - Drives out_rule_valid=1, out_rule_last=1, out_rule_id=0.
//    - On out_rule_ready: one-cycle in_meta_ready pulse (next cycle), then IDLE.
//  Latency and throughput
//   - Word handshake in cycle N: first rule beat valid in N+1.
//   - Sustains one beat per cycle while out_rule_ready=1.
//   - Each LOAD costs one bubble cycle.
//   - Slots are emitted in ascending index order.
//  Output handshake: out_rule_id, out_rule_last, out_meta_data stay stable while valid&!ready.
//   No beat is dropped or duplicated.
//  Empty packet (all eop-word slots zero, no earlier rules): exactly one terminator beat.
//  Counters: +1 on each handshaken beat, wrap 2^32-1 -> 0.
//   rule_cnt counts beats with last=0; pkt_cnt counts beats with last=1.
//  Meta is popped only after the terminator handshake.
//   in_meta_valid dropping mid-packet has no effect.
// STRUCTURE
//  Shared package (struct_s.sv)
//   - metadata_t and RULE_AWIDTH are already defined there.
//   - Add PG_SLOT_WIDTH=16, PG_NUM_SLOTS=32, and the state enum pgu_state_t {IDLE,LOAD,SCAN,TERM}.
//  Sub-module slot_pri_enc
//   - 32-bit mask in; 5-bit index of lowest set bit plus any-set flag out.
//   - Combinational; instantiated once.
// TESTING
//  1. One eop word with slot0=0x0005, slot9=0x0123, slot31=0x1FFF, ready=1
//     -> IDs 0x5, 0x123, 0x1FFF in consecutive cycles, then id 0 with last=1.
//     -> One in_meta_ready pulse; rule_cnt=3, pkt_cnt=1.
//  2. All-zero eop word -> one beat, id 0, last=1; rule_cnt unchanged; pkt_cnt+1.
//  3. Non-eop word with slots 0..31 = 1..32, then eop word with slot3=0x40
//     -> 33 beats in order 1..32, 0x40, then terminator; rule_cnt=33.
//  4. Scenario 1 with out_rule_ready toggling 1,0,1,0
//     -> outputs held during stall cycles; same 4-beat sequence, no loss or duplicate.
//  5. Slot value 0xE000 (pad bits only) plus slot2=0x0007
//     -> only ID 0x7 emitted, then terminator.
//  6. rst_n low during SCAN of scenario 3
//     -> all outputs 0 in the same cycle (asynchronous).
//     -> After release, scenario 1 runs correctly with counters restarted at 0.

Source files
------------

// File: rtl/pg_match_unpacker_pkg.sv
// Shared types and constants for the port-group match-stream unpacker.
// Metadata layout and rule-ID width are common to the host/check side.
package pg_match_unpacker_pkg;

  localparam int unsigned RULE_AWIDTH    = 13;
  localparam int unsigned PG_DATA_WIDTH  = 512;
  localparam int unsigned PG_SLOT_WIDTH  = 16;
  localparam int unsigned PG_NUM_SLOTS   = PG_DATA_WIDTH / PG_SLOT_WIDTH;
  localparam int unsigned PG_SLOT_IDX_W  = $clog2(PG_NUM_SLOTS);
  localparam int unsigned PG_EMPTY_WIDTH = 6;

  typedef struct packed {
    logic [15:0] flow_id;
    logic [7:0]  port_group;
    logic [7:0]  flags;
  } metadata_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN,
    TERM
  } pgu_state_t;

  // A slot is occupied when its rule-ID field is non-zero; pad bits never count.
  function automatic logic [PG_NUM_SLOTS-1:0] slot_occupancy(
    input logic [PG_DATA_WIDTH-1:0] data
  );
    logic [PG_NUM_SLOTS-1:0] occ;
    occ = '0;
    for (int unsigned k = 0; k < PG_NUM_SLOTS; k++) begin
      occ[k] = |data[k*PG_SLOT_WIDTH +: RULE_AWIDTH];
    end
    return occ;
  endfunction

endpackage

// File: rtl/pg_match_unpacker_if.sv
// Handshake bundle of the unpacker: match-word input, metadata input, rule-beat output.
// slave is the unpacker side; master is the producer/consumer environment.
interface pg_match_unpacker_if;
  import pg_match_unpacker_pkg::*;

  logic [PG_DATA_WIDTH-1:0]  in_match_data;
  logic                      in_match_valid;
  logic                      in_match_eop;
  logic                      in_match_sop;
  logic [PG_EMPTY_WIDTH-1:0] in_match_empty;
  logic                      in_match_ready;

  logic                      in_meta_valid;
  metadata_t                 in_meta_data;
  logic                      in_meta_ready;

  logic                      out_rule_valid;
  logic [RULE_AWIDTH-1:0]    out_rule_id;
  logic                      out_rule_last;
  metadata_t                 out_meta_data;
  logic                      out_rule_ready;

  modport slave (
    input  in_match_data, in_match_valid, in_match_eop, in_match_sop, in_match_empty,
    output in_match_ready,
    input  in_meta_valid, in_meta_data,
    output in_meta_ready,
    output out_rule_valid, out_rule_id, out_rule_last, out_meta_data,
    input  out_rule_ready
  );

  modport master (
    output in_match_data, in_match_valid, in_match_eop, in_match_sop, in_match_empty,
    input  in_match_ready,
    output in_meta_valid, in_meta_data,
    input  in_meta_ready,
    input  out_rule_valid, out_rule_id, out_rule_last, out_meta_data,
    output out_rule_ready
  );

endinterface

// File: rtl/pg_match_unpacker_slot_pri_enc.sv
// Lowest-set-bit priority encoder over the slot occupancy mask.
module slot_pri_enc
  import pg_match_unpacker_pkg::*;
(
  input  logic [PG_NUM_SLOTS-1:0]  i_mask,
  output logic [PG_SLOT_IDX_W-1:0] o_idx,
  output logic                     o_any
);

  logic w_found;

  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < PG_NUM_SLOTS; i++) begin
      if (i_mask[i] && !w_found) begin
        o_idx   = i[PG_SLOT_IDX_W-1:0];
        w_found = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/pg_match_unpacker.sv
// Unpacks 512-bit packed rule-match words into serial rule-ID beats per packet,
// closing each packet with a terminator beat and then popping its metadata record.
module pg_match_unpacker
  import pg_match_unpacker_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  pg_match_unpacker_if.slave  bus,
  output logic [31:0]         rule_cnt,
  output logic [31:0]         pkt_cnt
);

  pgu_state_t r_state;
  pgu_state_t w_state_nxt;

  logic [PG_NUM_SLOTS-1:0]                  r_mask;
  logic [PG_NUM_SLOTS-1:0][RULE_AWIDTH-1:0] r_ids;
  logic                                     r_eop;
  logic                                     r_meta_pop;
  metadata_t                                r_meta;
  logic [31:0]                              r_rule_cnt;
  logic [31:0]                              r_pkt_cnt;

  logic [PG_NUM_SLOTS-1:0]                  w_occ;
  logic [PG_NUM_SLOTS-1:0][RULE_AWIDTH-1:0] w_ids_in;
  logic [PG_NUM_SLOTS-1:0]                  w_mask_clr;
  logic [PG_SLOT_IDX_W-1:0]                 w_idx;
  logic                                     w_any;
  logic                                     w_word_hs;
  logic                                     w_beat_hs;
  logic                                     w_meta_take;
  logic                                     w_unused;

  slot_pri_enc u_pri_enc (
    .i_mask (r_mask),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_comb begin
    w_occ    = slot_occupancy(bus.in_match_data);
    w_ids_in = '0;
    for (int unsigned k = 0; k < PG_NUM_SLOTS; k++) begin
      w_ids_in[k] = bus.in_match_data[k*PG_SLOT_WIDTH +: RULE_AWIDTH];
    end
  end

  // Pad bits, sop and empty carry nothing the unpacker needs.
  always_comb begin
    w_unused = ^{bus.in_match_sop, bus.in_match_empty};
    for (int unsigned k = 0; k < PG_NUM_SLOTS; k++) begin
      w_unused = w_unused ^ (^bus.in_match_data[k*PG_SLOT_WIDTH + RULE_AWIDTH +: PG_SLOT_WIDTH - RULE_AWIDTH]);
    end
  end

  always_comb begin
    w_mask_clr        = r_mask;
    w_mask_clr[w_idx] = 1'b0;
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_meta_take        = 1'b0;
    bus.in_match_ready = 1'b0;
    bus.out_rule_valid = 1'b0;
    bus.out_rule_last  = 1'b0;
    bus.out_rule_id    = '0;
    case (r_state)
      IDLE: begin
        // The record just popped is still visible during the pop cycle; skip it.
        if (bus.in_meta_valid && !r_meta_pop) begin
          w_meta_take = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        bus.in_match_ready = 1'b1;
        if (bus.in_match_valid) begin
          if (|w_occ)                 w_state_nxt = SCAN;
          else if (bus.in_match_eop)  w_state_nxt = TERM;
          else                        w_state_nxt = LOAD;
        end
      end
      SCAN: begin
        bus.out_rule_valid = w_any;
        bus.out_rule_id    = r_ids[w_idx];
        if (bus.out_rule_ready && w_any && (w_mask_clr == '0)) begin
          w_state_nxt = r_eop ? TERM : LOAD;
        end
      end
      TERM: begin
        bus.out_rule_valid = 1'b1;
        bus.out_rule_last  = 1'b1;
        if (bus.out_rule_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_word_hs = bus.in_match_valid && bus.in_match_ready;
  assign w_beat_hs = bus.out_rule_valid && bus.out_rule_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mask     <= '0;
      r_ids      <= '0;
      r_eop      <= 1'b0;
      r_meta_pop <= 1'b0;
      r_meta     <= '0;
      r_rule_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_meta_pop <= (r_state == TERM) && bus.out_rule_ready;
      if (w_meta_take) begin
        r_meta <= bus.in_meta_data;
      end
      if (w_word_hs) begin
        r_mask <= w_occ;
        r_ids  <= w_ids_in;
        r_eop  <= bus.in_match_eop;
      end else if ((r_state == SCAN) && bus.out_rule_ready) begin
        r_mask <= w_mask_clr;
      end
      if (w_beat_hs) begin
        if (bus.out_rule_last) r_pkt_cnt  <= r_pkt_cnt + 32'd1;
        else                   r_rule_cnt <= r_rule_cnt + 32'd1;
      end
    end
  end

  assign bus.in_meta_ready = r_meta_pop;
  assign bus.out_meta_data = r_meta;
  assign rule_cnt          = r_rule_cnt;
  assign pkt_cnt           = r_pkt_cnt;

endmodule

// File: tb/tb_pg_match_unpacker.sv
// Scoreboard bench: packets are expanded into expected beats by a slot-walk model;
// a negedge monitor compares every presented beat against the queue head.
module tb_pg_match_unpacker;
  import pg_match_unpacker_pkg::*;

  typedef struct packed {
    logic                   last;
    logic [RULE_AWIDTH-1:0] id;
    metadata_t              meta;
  } beat_t;

  typedef struct packed {
    logic [PG_DATA_WIDTH-1:0] data;
    logic                     eop;
  } word_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] rule_cnt;
  logic [31:0] pkt_cnt;

  always #5 clk = ~clk;

  pg_match_unpacker_if bus ();

  pg_match_unpacker u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .rule_cnt (rule_cnt),
    .pkt_cnt  (pkt_cnt)
  );

  beat_t       exp_q[$];
  word_t       word_q[$];
  metadata_t   meta_q[$];
  word_t       stage[$];
  int unsigned acc_cyc[$];

  int unsigned n_checks  = 0;
  int unsigned n_fail    = 0;
  int unsigned exp_rule  = 0;
  int unsigned exp_pkt   = 0;
  int unsigned pops_seen = 0;
  int unsigned cyc_now   = 0;
  int unsigned ready_mode = 0;
  int unsigned gap_pct    = 0;
  logic        tgl = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endfunction

  // Reference model: walk every slot of every word in order, keep non-zero IDs.
  function automatic void commit_packet(metadata_t m);
    logic [15:0] v;
    for (int i = 0; i < stage.size(); i++) begin
      word_q.push_back(stage[i]);
      for (int k = 0; k < 32; k++) begin
        v = stage[i].data[k*16 +: 16];
        if ((v % 16'd8192) != 16'd0) begin
          exp_q.push_back(beat_t'{last: 1'b0, id: 13'(v % 16'd8192), meta: m});
          exp_rule++;
        end
      end
    end
    exp_q.push_back(beat_t'{last: 1'b1, id: '0, meta: m});
    exp_pkt++;
    meta_q.push_back(m);
    stage.delete();
  endfunction

  always @(posedge clk) cyc_now <= cyc_now + 1;

  // Driver: producer FIFOs for words and metadata, plus the downstream ready pattern.
  initial begin
    logic hs_w, hs_m;
    bus.in_match_data  = '0;
    bus.in_match_valid = 1'b0;
    bus.in_match_eop   = 1'b0;
    bus.in_match_sop   = 1'b0;
    bus.in_match_empty = '0;
    bus.in_meta_valid  = 1'b0;
    bus.in_meta_data   = '0;
    bus.out_rule_ready = 1'b1;
    forever begin
      @(negedge clk);
      hs_w = rst_n && bus.in_match_valid && bus.in_match_ready;
      hs_m = rst_n && bus.in_meta_ready;
      @(posedge clk);
      #1;
      if (hs_w && word_q.size() > 0) void'(word_q.pop_front());
      if (hs_m && meta_q.size() > 0) void'(meta_q.pop_front());
      if (word_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        bus.in_match_valid = 1'b1;
        bus.in_match_data  = word_q[0].data;
        bus.in_match_eop   = word_q[0].eop;
      end else begin
        bus.in_match_valid = 1'b0;
        for (int k = 0; k < 16; k++) bus.in_match_data[k*32 +: 32] = $urandom;
        bus.in_match_eop   = 1'($urandom);
      end
      bus.in_match_sop   = 1'($urandom);
      bus.in_match_empty = 6'($urandom);
      bus.in_meta_valid  = (meta_q.size() > 0);
      bus.in_meta_data   = (meta_q.size() > 0) ? meta_q[0] : metadata_t'($urandom);
      case (ready_mode)
        0: bus.out_rule_ready = 1'b1;
        1: begin bus.out_rule_ready = tgl; tgl = ~tgl; end
        default: bus.out_rule_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // Monitor: every presented beat must equal the scoreboard head; pop on acceptance.
  initial begin
    beat_t act;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.in_meta_ready) pops_seen++;
        if (bus.out_rule_valid) begin
          act = beat_t'{last: bus.out_rule_last, id: bus.out_rule_id, meta: bus.out_meta_data};
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat", act);
          end else begin
            check("beat", 64'(act), 64'(exp_q[0]));
            if (bus.out_rule_ready) begin
              void'(exp_q.pop_front());
              acc_cyc.push_back(cyc_now);
            end
          end
        end
      end
    end
  end

  task automatic drain(string name);
    int unsigned cyc = 0;
    while ((exp_q.size() != 0 || word_q.size() != 0 || meta_q.size() != 0) && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    check({name, "_timeout"}, 64'(cyc < 5000), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "_rule_cnt"}, 64'(rule_cnt), 64'(exp_rule));
    check({name, "_pkt_cnt"},  64'(pkt_cnt),  64'(exp_pkt));
    check({name, "_meta_pops"}, 64'(pops_seen), 64'(exp_pkt));
  endtask

  task automatic build_scn1();
    logic [PG_DATA_WIDTH-1:0] d;
    d = '0;
    d[0*16 +: 16]  = 16'h0005;
    d[9*16 +: 16]  = 16'h0123;
    d[31*16 +: 16] = 16'h1FFF;
    stage.push_back(word_t'{data: d, eop: 1'b1});
  endtask

  task automatic build_scn3();
    logic [PG_DATA_WIDTH-1:0] d;
    d = '0;
    for (int k = 0; k < 32; k++) d[k*16 +: 16] = 16'(k + 1);
    stage.push_back(word_t'{data: d, eop: 1'b0});
    d = '0;
    d[3*16 +: 16] = 16'h0040;
    stage.push_back(word_t'{data: d, eop: 1'b1});
  endtask

  initial begin
    logic [PG_DATA_WIDTH-1:0] d;
    int unsigned cyc;
    int unsigned nw;

    #1 rst_n = 1'b0;
    #2;
    check("reset_outputs",
          64'({bus.out_rule_valid, bus.out_rule_last, bus.out_rule_id, bus.out_meta_data,
               bus.in_match_ready, bus.in_meta_ready}), 64'd0);
    check("reset_counters", {rule_cnt, pkt_cnt}, 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Three rules in one eop word, back-to-back beats.
    acc_cyc.delete();
    build_scn1();
    commit_packet(metadata_t'({16'hA001, 8'h11, 8'h22}));
    drain("scn1");
    check("scn1_beats", 64'(acc_cyc.size()), 64'd4);
    if (acc_cyc.size() == 4) check("scn1_back_to_back", 64'(acc_cyc[3] - acc_cyc[0]), 64'd3);

    // Empty packet.
    stage.push_back(word_t'{data: '0, eop: 1'b1});
    commit_packet(metadata_t'({16'hA002, 8'h33, 8'h44}));
    drain("scn2");

    // 32 full slots then one more word.
    build_scn3();
    commit_packet(metadata_t'({16'hA003, 8'h55, 8'h66}));
    drain("scn3");

    // Stalling downstream.
    ready_mode = 1;
    tgl = 1'b0;
    build_scn1();
    commit_packet(metadata_t'({16'hA004, 8'h77, 8'h88}));
    drain("scn4");
    ready_mode = 0;

    // Pad-only slot is not a rule.
    d = '0;
    d[1*16 +: 16] = 16'hE000;
    d[2*16 +: 16] = 16'h0007;
    stage.push_back(word_t'{data: d, eop: 1'b1});
    commit_packet(metadata_t'({16'hA005, 8'h99, 8'hAA}));
    drain("scn5");

    // Random packets, random gaps and backpressure.
    ready_mode = 2;
    gap_pct = 30;
    for (int p = 0; p < 12; p++) begin
      nw = $urandom_range(3, 1);
      for (int w = 0; w < nw; w++) begin
        d = '0;
        if ($urandom_range(4) != 0) begin
          for (int k = 0; k < 32; k++) begin
            if ($urandom_range(3) == 0) d[k*16 +: 16] = 16'($urandom);
            else if ($urandom_range(7) == 0) d[k*16 +: 16] = {3'($urandom), 13'd0};
          end
        end
        stage.push_back(word_t'{data: d, eop: (w == nw - 1)});
      end
      commit_packet(metadata_t'($urandom));
    end
    drain("rand");
    ready_mode = 0;
    gap_pct = 0;

    // Asynchronous reset in the middle of a scan.
    build_scn3();
    commit_packet(metadata_t'({16'hA006, 8'hBB, 8'hCC}));
    cyc = 0;
    while (exp_q.size() > 20 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    check("scn6_reach_scan", 64'(cyc < 2000), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("scn6_async_reset",
          64'({bus.out_rule_valid, bus.out_rule_last, bus.out_rule_id, bus.out_meta_data,
               bus.in_match_ready, bus.in_meta_ready}), 64'd0);
    check("scn6_reset_counters", {rule_cnt, pkt_cnt}, 64'd0);
    exp_q.delete();
    word_q.delete();
    meta_q.delete();
    exp_rule  = 0;
    exp_pkt   = 0;
    pops_seen = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    build_scn1();
    commit_packet(metadata_t'({16'hA007, 8'hDD, 8'hEE}));
    drain("scn6_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $fatal(1);
  end

endmodule
